// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared state encoding, word size and burst range helper
package mem_burst_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, WRITE, READ, RESP} mbm_state_e;
  localparam int unsigned WORD_BYTES = 4;
  // True when the burst ends at or below the top of the memory; 64-bit math so address overflow cannot wrap into range
  function automatic logic burst_in_range(input logic [63:0] addr, input logic [3:0] len, input int unsigned depth);
    logic [63:0] end_a;
    end_a = addr + 64'(WORD_BYTES) * (64'(len) + 64'd1);
    return end_a <= 64'(WORD_BYTES) * 64'(depth);
  endfunction
endpackage

// File: rtl/mbm_addr_check.sv
// mbm_addr_check: combinational alignment and range check of a latched burst request
module mbm_addr_check import mem_burst_pkg::*; #(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [3:0]            len_i,
  output logic                  err_o
);
  assign err_o = (addr_i[1:0] != 2'd0) || !burst_in_range(64'(addr_i), len_i, MEMORY_DEPTH);
endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: burst request to word-access controller driving a single-port memory
module mem_burst_master import mem_burst_pkg::*; #(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [3:0]            req_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_last_o,
  output logic                  rsp_err_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  mbm_state_e state_q, state_d;
  logic write_q, write_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, rsp_data_q, rsp_data_d, next_addr;
  logic [3:0] beats_q, beats_d;
  logic rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
  logic chk_err;
  mbm_addr_check #(.MEMORY_DEPTH(MEMORY_DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_check (
    .addr_i(addr_q),
    .len_i (beats_q),
    .err_o (chk_err)
  );
  assign next_addr = addr_q + DATA_WIDTH'(WORD_BYTES);
  assign req_ready_o = state_q == IDLE;
  assign wdata_ready_o = state_q == WRITE;
  assign mem_we_o = wdata_ready_o && wdata_valid_i;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_ready_o ? wdata_i : '0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_last_o = rsp_last_q;
  assign rsp_err_o = rsp_err_q;
  // Next-state, counter and response-register logic of the burst FSM
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d = addr_q;
    beats_d = beats_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        state_d = CHECK;
        write_d = req_write_i;
        addr_d = req_addr_i;
        beats_d = req_len_i;
      end
      CHECK: begin
        state_d = chk_err ? RESP : (write_q ? WRITE : READ);
        rsp_valid_d = chk_err;
        rsp_err_d = chk_err;
        rsp_last_d = chk_err;
        rsp_data_d = '0;
      end
      WRITE: if (wdata_valid_i) begin
        addr_d = next_addr;
        beats_d = beats_q - 4'd1;
        if (beats_q == 4'd0) begin
          state_d = RESP;
          rsp_valid_d = 1'b1;
          rsp_last_d = 1'b1;
          rsp_err_d = 1'b0;
          rsp_data_d = '0;
        end
      end
      READ: begin
        state_d = RESP;
        rsp_valid_d = 1'b1;
        rsp_last_d = beats_q == 4'd0;
        rsp_err_d = 1'b0;
        rsp_data_d = mem_rdata_i;
      end
      RESP: if (rsp_ready_i) begin
        rsp_valid_d = 1'b0;
        rsp_last_d = 1'b0;
        rsp_err_d = 1'b0;
        rsp_data_d = '0;
        state_d = (!write_q && !rsp_err_q && beats_q != 4'd0) ? READ : IDLE;
        if (!write_q && !rsp_err_q && beats_q != 4'd0) begin
          addr_d = next_addr;
          beats_d = beats_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q <= '0;
      beats_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q <= addr_d;
      beats_q <= beats_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: table, directed and random bursts against a memory-array reference model
module tb_mem_burst_master;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid_i = 1'b0, req_write_i = 1'b0, wdata_valid_i = 1'b0, rsp_ready_i = 1'b0;
  logic [31:0] req_addr_i = '0, wdata_i = '0, mem_rdata_i;
  logic [3:0] req_len_i = '0;
  logic req_ready_o, wdata_ready_o, rsp_valid_o, rsp_last_o, rsp_err_o, mem_we_o;
  logic [31:0] rsp_data_o, mem_addr_o, mem_wdata_o;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] wbuf [16];
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t wlog[$];
  typedef struct {logic wr; logic [31:0] addr; logic [3:0] len; logic err;} vec_t;
  vec_t vecs[10];
  int errors = 0, checks = 0;

  mem_burst_master #(.MEMORY_DEPTH(64), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;
  assign mem_rdata_i = mem[mem_addr_o[7:2]];
  always @(negedge clk) if (mem_we_o) begin
    mem[mem_addr_o[7:2]] <= mem_wdata_o;
    wlog.push_back('{mem_addr_o, mem_wdata_o});
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [3:0] l);
    logic [63:0] e;
    e = {32'd0, a} + 64'd4 * (64'(l) + 64'd1);
    return (a[1:0] != 2'd0) || (e > 64'd256);
  endfunction

  task automatic send_req(input logic wr, input logic [31:0] a, input logic [3:0] l);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i = a;
    req_len_i = l;
    step;
    req_valid_i = 1'b0;
  endtask

  task automatic feed_wdata(input logic [3:0] l, input logic gap);
    int b = 0, n = 0;
    while (b <= int'(l) && n < 200) begin
      wdata_valid_i = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata_i = wbuf[b];
      @(negedge clk);
      if (wdata_ready_o && wdata_valid_i) b++;
      step;
      n++;
    end
    wdata_valid_i = 1'b0;
    if (n >= 200) chk("wdata_timeout", 32'(b), 32'(l) + 32'd1);
    @(negedge clk);
    chk("ack_next_cycle", 32'(rsp_valid_o), 32'd1);
    step;
  endtask

  task automatic collect(input logic wr, input logic [31:0] a, input logic [3:0] l, input logic e, input logic rnd);
    int nb = 0, n = 0, exp_beats;
    logic done = 1'b0;
    exp_beats = (e || wr) ? 1 : int'(l) + 1;
    while (!done && n < 400) begin
      rsp_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) begin
        chk("rsp_err", 32'(rsp_err_o), 32'(e));
        chk("rsp_data", rsp_data_o, (e || wr) ? 32'd0 : ref_mem[((a >> 2) + 32'(nb)) & 32'd63]);
        chk("rsp_last", 32'(rsp_last_o), 32'(nb == exp_beats - 1));
        nb++;
        done = rsp_last_o || nb >= exp_beats;
      end
      step;
      n++;
    end
    rsp_ready_i = 1'b0;
    chk("rsp_beats", 32'(nb), 32'(exp_beats));
  endtask

  task automatic burst(input logic wr, input logic [31:0] a, input logic [3:0] l, input logic e, input logic gap, input logic rnd);
    wlog.delete();
    send_req(wr, a, l);
    if (wr && !e) feed_wdata(l, gap);
    collect(wr, a, l, e, rnd);
    if (wr && !e) begin
      chk("wr_count", 32'(wlog.size()), 32'(l) + 32'd1);
      for (int i = 0; i < wlog.size() && i <= int'(l); i++) begin
        chk("wr_addr", wlog[i].addr, a + 32'(4 * i));
        chk("wr_data", wlog[i].data, wbuf[i]);
      end
      for (int i = 0; i <= int'(l); i++) ref_mem[((a >> 2) + 32'(i)) & 32'd63] = wbuf[i];
    end else chk("no_write", 32'(wlog.size()), 32'd0);
  endtask

  initial begin
    int n, b;
    logic [3:0] pat;
    logic [31:0] a;
    logic [3:0] l;
    logic wr;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    vecs[0] = '{1'b0, 32'h0000_0012, 4'd0, 1'b1};
    vecs[1] = '{1'b0, 32'h0000_00FC, 4'd0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_00FC, 4'd1, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFF0, 4'd15, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0012, 4'd0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_00F0, 4'd3, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_00F0, 4'd4, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_00F0, 4'd3, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_0000, 4'd15, 1'b0};
    vecs[9] = '{1'b1, 32'hFFFF_FFFC, 4'd0, 1'b1};
    repeat (3) step;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_wdata_ready", 32'(wdata_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_data", rsp_data_o, 32'd0);
    chk("rst_rsp_last", 32'(rsp_last_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    step;
    reset = 1'b0;
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    burst(1'b1, 32'h10, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("model_A", ref_mem[4], 32'hA);
    burst(1'b0, 32'h10, 4'd3, 1'b0, 1'b0, 1'b0);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h20; req_len_i = 4'd0;
    @(negedge clk);
    chk("lat_ready_idle", 32'(req_ready_o), 32'd1);
    step;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("lat_ready_low", 32'(req_ready_o), 32'd0);
    chk("lat_valid_check", 32'(rsp_valid_o), 32'd0);
    step;
    @(negedge clk);
    chk("lat_valid_read", 32'(rsp_valid_o), 32'd0);
    chk("lat_addr", mem_addr_o, 32'h20);
    chk("lat_no_we", 32'(mem_we_o), 32'd0);
    step;
    @(negedge clk);
    chk("lat_valid", 32'(rsp_valid_o), 32'd1);
    chk("lat_data", rsp_data_o, ref_mem[8]);
    step;
    collect(1'b0, 32'h20, 4'd0, 1'b0, 1'b0);
    send_req(1'b0, 32'h40, 4'd2);
    n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_first_valid", 32'(rsp_valid_o), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_data", rsp_data_o, ref_mem[16]);
      chk("bp_addr", mem_addr_o, 32'h40);
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
    end
    step;
    collect(1'b0, 32'h40, 4'd2, 1'b0, 1'b0);
    wlog.delete();
    wbuf[0] = $urandom; wbuf[1] = $urandom;
    send_req(1'b1, 32'h80, 4'd1);
    wdata_valid_i = 1'b0;
    step;
    pat = 4'b1001;
    b = 0;
    for (int k = 0; k < 4; k++) begin
      wdata_valid_i = pat[3 - k];
      wdata_i = wbuf[b & 1];
      @(negedge clk);
      if (wdata_valid_i && wdata_ready_o) b++;
      step;
    end
    wdata_valid_i = 1'b0;
    collect(1'b1, 32'h80, 4'd1, 1'b0, 1'b0);
    chk("gap_count", 32'(wlog.size()), 32'd2);
    for (int i = 0; i < wlog.size() && i < 2; i++) begin
      chk("gap_addr", wlog[i].addr, 32'h80 + 32'(4 * i));
      chk("gap_data", wlog[i].data, wbuf[i]);
    end
    ref_mem[32] = wbuf[0]; ref_mem[33] = wbuf[1];
    wlog.delete();
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    send_req(1'b1, 32'hA0, 4'd7);
    step;
    for (int k = 0; k < 2; k++) begin
      wdata_valid_i = 1'b1;
      wdata_i = wbuf[k];
      step;
    end
    wdata_valid_i = 1'b0;
    reset = 1'b1;
    step;
    reset = 1'b0;
    wdata_valid_i = 1'b1;
    wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rr_req_ready", 32'(req_ready_o), 32'd1);
    chk("rr_wdata_ready", 32'(wdata_ready_o), 32'd0);
    chk("rr_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rr_rsp_data", rsp_data_o, 32'd0);
    chk("rr_rsp_last", 32'(rsp_last_o), 32'd0);
    chk("rr_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rr_mem_we", 32'(mem_we_o), 32'd0);
    chk("rr_mem_addr", mem_addr_o, 32'd0);
    chk("rr_mem_wdata", mem_wdata_o, 32'd0);
    step;
    wdata_valid_i = 1'b0;
    chk("rr_count", 32'(wlog.size()), 32'd2);
    chk("rr_beat0", mem[40], wbuf[0]);
    chk("rr_beat1", mem[41], wbuf[1]);
    for (int i = 2; i < 8; i++) chk("rr_untouched", mem[40 + i], ref_mem[40 + i]);
    ref_mem[40] = wbuf[0]; ref_mem[41] = wbuf[1];
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      burst(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].err, 1'b0, 1'b0);
    end
    for (int r = 0; r < 30; r++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63) * 4 + (($urandom_range(0, 7) == 0) ? 2 : 0));
      l = 4'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      burst(wr, a, l, model_err(a, l), 1'b1, 1'b1);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Initiator-side controller for the single-port data memory (clk, write enable, byte address, write data, read data). It accepts one burst request at a time over a valid/ready handshake, breaks it into word accesses with an incrementing address, and drives the memory port. Write data arrives per beat over a second handshake, and read data is returned per beat over a response handshake. It sits between the CPU load/store path (or a DMA client) and the memory system, which it instantiates nothing of: it only drives that port.

## Interface
- `MEMORY_DEPTH`, 64: words in the target memory.
- `DATA_WIDTH`, 32: data and address width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid_i` in 1: request offered.
- `req_ready_o` out 1: controller idle and accepting a request.
- `req_write_i` in 1: 1 = write burst, 0 = read burst.
- `req_addr_i` in DATA_WIDTH: start byte address.
- `req_len_i` in 4: beats minus one (0..15 gives 1..16 beats).
- `wdata_valid_i` in 1: write beat data offered.
- `wdata_ready_o` out 1: write beat accepted this cycle.
- `wdata_i` in DATA_WIDTH: write beat data.
- `rsp_valid_o` out 1: response beat valid.
- `rsp_ready_i` in 1: consumer takes the response beat.
- `rsp_data_o` out DATA_WIDTH: read data (0 for write/error responses).
- `rsp_last_o` out 1: final beat of the burst.
- `rsp_err_o` out 1: request rejected (misaligned or out of range).
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o` out DATA_WIDTH: memory byte address.
- `mem_wdata_o` out DATA_WIDTH: memory write data.
- `mem_rdata_i` in DATA_WIDTH: memory read data, combinational from `mem_addr_o` (same-cycle).

## Operation
- **States**: IDLE, CHECK, WRITE, READ, RESP.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`, latch write flag, address, and len into `addr_q`/`beats_q` (the handshake fires), then go to CHECK.
- **CHECK** (1 cycle)
  - Error if `addr[1:0]`≠0, or if `addr + 4*(len+1) > 4*MEMORY_DEPTH`. Compute the sum in DATA_WIDTH+1 bits so overflow counts as error.
  - On error: go to RESP with `err`=1, `last`=1, `data`=0. No memory access occurs.
  - Otherwise go to WRITE or READ.
- **WRITE**
  - `wdata_ready_o`=1.
  - `mem_we_o` = `wdata_valid_i`; `mem_addr_o`=`addr_q`; `mem_wdata_o`=`wdata_i`. This is a combinational pass-through, so a write occurs only on the cycle of a beat handshake.
  - Per accepted beat: `addr_q`+=4, `beats_q`−=1.
  - After the final beat, go to RESP with one write-acknowledge beat (`last`=1, `err`=0, `data`=0).
- **READ**
  - `mem_we_o`=0, `mem_addr_o`=`addr_q`.
  - Capture `mem_rdata_i` into `rsp_data_q`, set `rsp_valid`, go to RESP.
- **RESP**
  - Hold `rsp_*` stable until `rsp_ready_i`.
  - On handshake: if the read burst has beats remaining, `addr_q`+=4, `beats_q`−=1, and return to READ. Otherwise return to IDLE.
  - `rsp_last_o`=1 on the final read beat.
- `mem_we_o` is 0 in every state except WRITE with `wdata_valid_i`=1.
- `reset` mid-burst abandons the burst: the state returns to IDLE immediately. Memory writes already performed remain.
- No new request is accepted until the response carrying `rsp_last_o` is taken.

## Timing
- **Reset values**: state IDLE, `req_ready_o`=1, `wdata_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_last_o`=0, `rsp_err_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- **Read latency**: request accepted at edge N; CHECK during N+1; READ during N+2; `rsp_valid_o` high from N+3.
- **Read throughput**: one beat per 2 cycles with `rsp_ready_i` held high.
- **Write throughput**: one beat per cycle while `wdata_valid_i` is held. The ack is valid the cycle after the last beat.
- `rsp_*` are registered outputs. `wdata_ready_o`, `mem_we_o`, and `mem_wdata_o` are combinational from state and `wdata_*`.
- `req_ready_o` deasserts in the cycle after the accept edge.

## Structure
- Package `mem_burst_pkg`: state enum `mbm_state_e`, constant `WORD_BYTES`=4, and function `burst_in_range(addr, len, depth)`.
- One natural sub-module: `mbm_addr_check`, the combinational alignment/range checker used in CHECK.
- Everything else is a single FSM plus the address and beat counters.

## Test plan
- Write len=3 at 0x10 with data 0xA,0xB,0xC,0xD, then read len=3 at 0x10. Required: four `mem_we_o` pulses at 0x10/0x14/0x18/0x1C, one ack, then read beats A,B,C,D with `last` only on D.
- Read at 0x12: `rsp_err_o`=1, `rsp_last_o`=1, `data`=0, and `mem_we_o` never asserts.
- Range edge: read len=0 at 0xFC passes. Read len=1 at 0xFC errors. Address 0xFFFFFFF0 with len=15 errors (overflow).
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles during a read. Required: `rsp_data_o` stable, `mem_addr_o` not advanced, `req_ready_o`=0.
- Write with gapped `wdata_valid_i` (1,0,0,1): exactly 2 writes, at consecutive addresses.
- Assert `reset` after beat 2 of a len=7 write. Required: next cycle IDLE, `req_ready_o`=1, all outputs at reset values. Beats 0–1 are in memory; beats 2–7 are not written.
